button_press_counter: RTL
=========================

// Module: button_press_counter
//
// PURPOSE
//   Upstream feeder for the 4-digit hex display: debounces two raw push-buttons
//   (increment, clear) and maintains the 16-bit value driven onto the display's
//   data[15:0] input. Holding increment auto-repeats. Output is binary (0000-FFFF)
//   or 4-digit BCD (0000-9999) so the display shows hex or decimal counts.
//
// PARAMETERS
//   DEBOUNCE_CYCLES  50000     stable-level cycles before a press/release is accepted (>=2)
//   REPEAT_DELAY     25000000  cycles from accepted inc press to first repeat; 0 = repeat off
//   REPEAT_PERIOD    5000000   cycles between subsequent repeats (>=1)
//   BCD              0         0 = binary count, 1 = per-nibble decimal count
//
// PORTS
//   clk        in   1   system clock
//   rst        in   1   asynchronous, active-high reset
//   btn_inc    in   1   raw increment button, active-high, asynchronous to clk
//   btn_clr    in   1   raw clear button, active-high, asynchronous to clk
//   data       out  16  counter value, connects to display data[15:0]
//   inc_pulse  out  1   one-cycle strobe per accepted increment (press or repeat)
//   clr_pulse  out  1   one-cycle strobe per accepted clear press
//
// BEHAVIOUR
//   - Reset: data=0, inc_pulse=0, clr_pulse=0, synchronisers=0, both FSMs IDLE, timers=0.
//   - Each button: 2-FF synchroniser; FSM acts on 2nd stage (s).
//   - Inc FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; shared timer t:
//     IDLE: s=1 -> PRESS_WAIT, t=0.
//     PRESS_WAIT: s=0 -> IDLE; t==DEBOUNCE_CYCLES-1 -> HELD, inc_pulse next cycle,
//       repeat timer r=0; else t++.
//     HELD: s=0 -> RELEASE_WAIT, t=0; else r++; r reaching REPEAT_DELAY (first) then
//       every REPEAT_PERIOD -> inc_pulse (never if REPEAT_DELAY=0).
//     RELEASE_WAIT: s=1 -> HELD, r restarts at 0 (full delay again), no pulse;
//       t==DEBOUNCE_CYCLES-1 -> IDLE; else t++.
//   - Clr FSM: same states/debounce, no repeat; clr_pulse only on PRESS_WAIT->HELD.
//   - Latency: btn rises before edge 1 and stays high -> PRESS_WAIT at edge 3,
//     pulse high after edge DEBOUNCE_CYCLES+3, data updated at edge DEBOUNCE_CYCLES+4.
//   - Glitch shorter than DEBOUNCE_CYCLES cycles: no pulse, no data change.
//   - Count update (registered, on the cycle a pulse is high):
//     clr_pulse -> data=0 (clear wins over simultaneous inc_pulse).
//     inc_pulse, BCD=0 -> data+1, FFFF wraps to 0000.
//     inc_pulse, BCD=1 -> decimal increment, digit 9 -> 0 with carry; 9999 -> 0000.
//     BCD=1: nibbles always 0-9.
//   - Both buttons held: independent FSMs; repeats on inc still cleared by each clr.
//   - rst mid-operation: everything returns to reset state immediately; a still-held
//     button must be re-debounced from IDLE (one fresh press accepted).
//   - Timer widths from $clog2 of largest parameter; no overflow in any state.
//
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 unless noted)
//   1 btn_inc high before edge 1, held 10 cycles -> inc_pulse high after edge 7 only, data 0000->0001 at edge 8.
//   2 btn_inc pulses of 3 cycles, low 3 cycles, x5 -> no inc_pulse, data stays 0000.
//   3 btn_inc held 60 cycles -> pulses at accept, +20, +28, +36, +44, +52: data=0006.
//   4 BCD=0 preload via 65535 presses (or forced) data=FFFF, one press -> 0000; BCD=1 data=0999 -> 1000, 9999 -> 0000.
//   5 btn_inc and btn_clr rise same cycle, data=0042 -> inc_pulse and clr_pulse same cycle, data=0000.
//   6 rst pulsed while btn_inc held in HELD, data=0005 -> data=0000 at once; after release of rst one new pulse -> 0001.

Source files
------------

// File: rtl/button_press_counter.sv
// Debounced increment/clear push-button counter with auto-repeat, feeding a
// 4-digit display. The count is binary (0000-FFFF) or per-nibble BCD (0000-9999).
module button_press_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned BCD             = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_clr,
  output logic [15:0] data,
  output logic        inc_pulse,
  output logic        clr_pulse
);

  localparam int unsigned MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int unsigned TW    = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] DEB_LAST    = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY  == 0) ? 0 : REPEAT_DELAY  - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);
  localparam bit            REPEAT_ON   = (REPEAT_DELAY != 0);
  localparam bit            USE_BCD     = (BCD != 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  logic [1:0]    inc_sync;
  logic [1:0]    clr_sync;
  logic          inc_s;
  logic          clr_s;

  btn_state_t    inc_state, inc_state_next;
  logic [TW-1:0] inc_t, inc_t_next;
  logic [TW-1:0] inc_r, inc_r_next;
  logic          inc_rep, inc_rep_next;
  logic          inc_pulse_next;

  btn_state_t    clr_state, clr_state_next;
  logic [TW-1:0] clr_t, clr_t_next;
  logic          clr_pulse_next;

  assign inc_s = inc_sync[1];
  assign clr_s = clr_sync[1];

  // Decimal increment: each nibble rolls 9 -> 0 and carries into the next one.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          res[i*4 +: 4] = 4'd0;
        end else begin
          res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Two-stage synchronisers for both raw buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_sync <= '0;
      clr_sync <= '0;
    end else begin
      inc_sync <= {inc_sync[0], btn_inc};
      clr_sync <= {clr_sync[0], btn_clr};
    end
  end

  // Increment FSM state, debounce/repeat timers and registered strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_state <= IDLE;
      inc_t     <= '0;
      inc_r     <= '0;
      inc_rep   <= 1'b0;
      inc_pulse <= 1'b0;
    end else begin
      inc_state <= inc_state_next;
      inc_t     <= inc_t_next;
      inc_r     <= inc_r_next;
      inc_rep   <= inc_rep_next;
      inc_pulse <= inc_pulse_next;
    end
  end

  // Increment FSM next state; inc_rep selects first-delay vs period phase of r.
  always_comb begin
    inc_state_next = inc_state;
    inc_t_next     = inc_t;
    inc_r_next     = inc_r;
    inc_rep_next   = inc_rep;
    inc_pulse_next = 1'b0;
    case (inc_state)
      IDLE: begin
        if (inc_s) begin
          inc_state_next = PRESS_WAIT;
          inc_t_next     = '0;
        end
      end
      PRESS_WAIT: begin
        if (!inc_s) begin
          inc_state_next = IDLE;
        end else if (inc_t == DEB_LAST) begin
          inc_state_next = HELD;
          inc_pulse_next = 1'b1;
          inc_r_next     = '0;
          inc_rep_next   = 1'b0;
        end else begin
          inc_t_next = inc_t + 1'b1;
        end
      end
      HELD: begin
        if (!inc_s) begin
          inc_state_next = RELEASE_WAIT;
          inc_t_next     = '0;
        end else if (REPEAT_ON) begin
          if (!inc_rep) begin
            if (inc_r == DELAY_LAST) begin
              inc_pulse_next = 1'b1;
              inc_r_next     = '0;
              inc_rep_next   = 1'b1;
            end else begin
              inc_r_next = inc_r + 1'b1;
            end
          end else begin
            if (inc_r == PERIOD_LAST) begin
              inc_pulse_next = 1'b1;
              inc_r_next     = '0;
            end else begin
              inc_r_next = inc_r + 1'b1;
            end
          end
        end
      end
      RELEASE_WAIT: begin
        if (inc_s) begin
          inc_state_next = HELD;
          inc_r_next     = '0;
          inc_rep_next   = 1'b0;
        end else if (inc_t == DEB_LAST) begin
          inc_state_next = IDLE;
        end else begin
          inc_t_next = inc_t + 1'b1;
        end
      end
      default: inc_state_next = IDLE;
    endcase
  end

  // Clear FSM state, debounce timer and registered strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state <= IDLE;
      clr_t     <= '0;
      clr_pulse <= 1'b0;
    end else begin
      clr_state <= clr_state_next;
      clr_t     <= clr_t_next;
      clr_pulse <= clr_pulse_next;
    end
  end

  // Clear FSM next state: same debounce as increment, no repeat.
  always_comb begin
    clr_state_next = clr_state;
    clr_t_next     = clr_t;
    clr_pulse_next = 1'b0;
    case (clr_state)
      IDLE: begin
        if (clr_s) begin
          clr_state_next = PRESS_WAIT;
          clr_t_next     = '0;
        end
      end
      PRESS_WAIT: begin
        if (!clr_s) begin
          clr_state_next = IDLE;
        end else if (clr_t == DEB_LAST) begin
          clr_state_next = HELD;
          clr_pulse_next = 1'b1;
        end else begin
          clr_t_next = clr_t + 1'b1;
        end
      end
      HELD: begin
        if (!clr_s) begin
          clr_state_next = RELEASE_WAIT;
          clr_t_next     = '0;
        end
      end
      RELEASE_WAIT: begin
        if (clr_s) begin
          clr_state_next = HELD;
        end else if (clr_t == DEB_LAST) begin
          clr_state_next = IDLE;
        end else begin
          clr_t_next = clr_t + 1'b1;
        end
      end
      default: clr_state_next = IDLE;
    endcase
  end

  // Count register: clear has priority over a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (clr_pulse) begin
      data <= '0;
    end else if (inc_pulse) begin
      data <= USE_BCD ? bcd_inc(data) : data + 16'd1;
    end
  end

endmodule
